shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Serial-to-parallel converter: the receiving end of the MSB-first serial link driven by the team's shift serializer. It collects one bit per accepted cycle into a TO-bit word and presents the completed word on a valid/ready parallel port. It sits between the serial link and the wide datapath that consumes whole words.

## Interface

- TO, 256, parallel word width in bits; must be at least 2.
- LOG2TO, 8, bit-counter width; equals $clog2(TO).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_i  in  1  serial data bit.
- valid_i  in  1  data_i carries a bit this cycle.
- ready_o  out  1  block accepts a serial bit this cycle.
- data_o  out  TO  assembled word; the first received bit is data_o[TO-1].
- valid_o  out  1  data_o holds a complete word.
- ready_i  in  1  consumer takes data_o this cycle.

## Operation

- A bit is accepted on a rising edge where valid_i && ready_o is 1. The shift register updates as Shift <= {Shift[TO-2:0], data_i}.
- The bit counter (LOG2TO bits) increments on each accepted bit. It clears to 0 when it accepts a bit while at TO-1; that bit completes the word.
- A word is transferred when valid_o && ready_i is 1.
- Cycles with valid_i=0 are ignored. Counter and shift register hold.
- Base FSM (no macro):
  - COLLECT (reset state): ready_o=1, valid_o=0. Accepting the bit that completes a word moves the FSM to HOLD and copies the full word into data_o.
  - HOLD: ready_o=0, valid_o=1, and data_o is stable. When ready_i=1, the word transfers and the FSM returns to COLLECT on the next edge.
- Arithmetic: the counter never exceeds TO-1. Non-power-of-2 TO is legal, because the counter wraps by compare, not by overflow.

## Timing

- Reset values: data_o = 0, valid_o = 0, ready_o = 1, counter = 0, shift register = 0, FSM in COLLECT.
- Reset mid-word discards all partial bits. Reset while valid_o=1 drops the pending word.
- Latency: valid_o rises on the edge that accepts the TO-th bit, so it is first visible one cycle after that bit is presented.
- A continuous valid_i stream yields one word every TO+1 cycles in base mode. This is a minimum; it holds when ready_i is tied to 1.
- ready_o is combinational from state only; it does not depend on valid_i or ready_i.
- valid_o, once asserted, stays at 1 with data_o unchanged until the transfer edge.
- The serializer holds valid high for FROM+1 cycles. Any bits offered while ready_o=0 are not accepted; the bench models this with the sender holding data until ready_o is 1.

## Configuration

- Macro: SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN.
- Undefined: behaviour is the base FSM above. ready_o=0 throughout HOLD.
- Defined: the shift register and the output register (data_o/valid_o) operate independently. Collection continues while a word waits on the output.
  - A completed word moves to the output register in either of two cases: the output register is empty, or the output register is transferring on the same edge. In both cases valid_o stays 1 with no bubble.
  - Otherwise the FSM enters STALL: ready_o=0 and the completed word is held in the shift register. On the edge with ready_i=1, the held word moves to the output register, and the FSM returns to COLLECT with ready_o=1 on the following cycle.
  - Sustained throughput: one word per TO cycles while ready_i=1.

## Test plan

- TO=8, ready_i=1, stream bits 1,0,1,1,0,0,1,0 with valid_i=1 → valid_o=1 one cycle after the last bit, data_o=8'hB2. valid_o falls the next cycle.
- TO=8, the same stream with valid_i low for 3 cycles between bits 4 and 5 → data_o=8'hB2; gaps do not corrupt the counter.
- TO=8, ready_i=0 for 10 cycles after the word completes (base mode) → data_o holds 8'hB2, ready_o=0 throughout, and no bits are accepted. Raising ready_i → one transfer, then ready_o=1.
- Reset asserted after 5 of 8 bits, then 8 fresh bits 0xFF → data_o=8'hFF. No residue from the partial word; outputs are 0/0/1 during reset.
- Macro defined, TO=8, continuous stream of words 0xA5, 0x3C with ready_i=1 → two transfers 8 cycles apart and ready_o never drops.
- Macro defined, ready_i=0 while two words arrive → the first word is on data_o and the second is held with ready_o=0. With ready_i=1 for 2 cycles → 0xA5 then 0x3C transfer in order, and ready_o returns to 1.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// Handshake bundle for shift_deserializer: serial input side and parallel word side.
// master drives the serial bits and the word-side ready; slave is the deserializer.
interface shift_deserializer_if #(
    parameter int TO = 256
);
    logic          data_i;
    logic          valid_i;
    logic          ready_o;
    logic [TO-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o
    );
endinterface

// File: rtl/shift_deserializer.sv
// MSB-first serial to TO-bit parallel word converter with valid/ready on both sides.
// Define SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN to keep collecting while a word waits.
module shift_deserializer #(
    parameter int TO     = 256,
    parameter int LOG2TO = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_deserializer_if.slave  bus
);
`ifdef SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN
    typedef enum logic {COLLECT, STALL} state_t;
`else
    typedef enum logic {COLLECT, HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [TO-1:0]     shift_q, word, data_q;
    logic [LOG2TO-1:0] cnt_q;
    logic              rdy, accept, last, done, valid;

    assign rdy    = (state_q == COLLECT);
    assign accept = bus.valid_i && rdy;
    assign last   = (cnt_q == LOG2TO'(TO - 1));
    assign done   = accept && last;
    assign word   = (shift_q << 1) | TO'(bus.data_i);

    assign bus.ready_o = rdy;
    assign bus.valid_o = valid;
    assign bus.data_o  = data_q;

    // Counter wraps by compare so any TO >= 2 works.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shift_q <= word;
            cnt_q   <= last ? '0 : cnt_q + LOG2TO'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= COLLECT;
        else        state_q <= state_d;
    end

`ifdef SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN
    logic load_new, load_held;

    // A finished word goes straight out if the output slot is free this edge.
    assign load_new  = done && (!valid || bus.ready_i);
    assign load_held = (state_q == STALL) && bus.ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (done && !load_new) state_d = STALL;
            STALL:   if (bus.ready_i)       state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            valid  <= 1'b0;
        end else if (load_new) begin
            data_q <= word;
            valid  <= 1'b1;
        end else if (load_held) begin
            data_q <= shift_q;
            valid  <= 1'b1;
        end else if (bus.ready_i) begin
            valid  <= 1'b0;
        end
    end
`else
    assign valid = (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (done)         state_d = HOLD;
            HOLD:    if (bus.ready_i)  state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    data_q <= '0;
        else if (done) data_q <= word;
    end
`endif
endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer (TO=8) against a word-queue model.
// The model tracks completed-but-untransferred words; capacity is 1 base, 2 double-buffered.
module tb_shift_deserializer;
    localparam int TO     = 8;
    localparam int LOG2TO = 3;
`ifdef SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    shift_deserializer_if #(.TO(TO)) bus ();

    shift_deserializer #(.TO(TO), .LOG2TO(LOG2TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            nb     = 0;
    logic [TO-1:0] part   = '0;
    logic [TO-1:0] q[$];
    int            xfer_cyc[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        xfer_cyc.delete();
        part = '0;
        nb   = 0;
    endtask

    // One clock: record handshakes, advance the model, check outputs.
    task automatic tick(output logic acc);
        logic fout, b;
        #1;
        acc  = bus.valid_i && bus.ready_o;
        fout = bus.valid_o && bus.ready_i;
        b    = bus.data_i;
        if (fout) begin
            if (q.size() == 0) check("xfer_spurious", 32'd1, 32'd0);
            else check("xfer_data", 32'(bus.data_o), 32'(q[0]));
        end
        @(posedge clk);
        cyc++;
        if (fout && q.size() != 0) begin
            void'(q.pop_front());
            xfer_cyc.push_back(cyc);
        end
        if (acc) begin
            part = {part[TO-2:0], b};
            nb++;
            if (nb == TO) begin
                q.push_back(part);
                nb = 0;
            end
        end
        @(negedge clk);
        check("valid_o", 32'(bus.valid_o), 32'(q.size() != 0));
        check("ready_o", 32'(bus.ready_o), 32'(q.size() < CAP));
        if (q.size() != 0) check("data_o", 32'(bus.data_o), 32'(q[0]));
    endtask

    task automatic send_bit(input logic b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.data_i  = b;
        bus.valid_i = 1'b1;
        while (!acc && n < 64) begin
            tick(acc);
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic a;
        bus.valid_i = 1'b0;
        repeat (n) tick(a);
    endtask

    task automatic send_word(input logic [TO-1:0] w, input int gap);
        for (int i = TO - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == TO - 4 && gap > 0) idle(gap);
        end
    endtask

    initial begin
        logic a;
        bus.data_i  = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        reset       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_data", 32'(bus.data_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back stream, consumer always ready.
        bus.ready_i = 1'b1;
        send_word(8'hB2, 0);
        check("t1_valid", 32'(bus.valid_o), 32'd1);
        check("t1_data", 32'(bus.data_o), 32'hB2);
        idle(1);
        check("t1_fall", 32'(bus.valid_o), 32'd0);

        // Three idle cycles between bits 4 and 5.
        send_word(8'hB2, 3);
        check("t2_data", 32'(bus.data_o), 32'hB2);
        idle(1);

`ifndef SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN
        // Consumer stalls; offered bits must be refused.
        bus.ready_i = 1'b0;
        send_word(8'hB2, 0);
        bus.valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_i = 1'($urandom_range(0, 1));
            tick(a);
            check("t3_noacc", 32'(a), 32'd0);
            check("t3_ready", 32'(bus.ready_o), 32'd0);
            check("t3_hold", 32'(bus.data_o), 32'hB2);
        end
        bus.ready_i = 1'b1;
        tick(a);
        check("t3_ready_back", 32'(bus.ready_o), 32'd1);
        check("t3_valid_drop", 32'(bus.valid_o), 32'd0);
        bus.valid_i = 1'b0;
`endif

        // Reset mid-word discards the partial bits.
        bus.ready_i = 1'b1;
        for (int i = TO - 1; i >= 3; i--) send_bit(1'(i % 2));
        reset = 1'b0;
        #1;
        check("t4_rst_data", 32'(bus.data_o), 32'd0);
        check("t4_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t4_rst_ready", 32'(bus.ready_o), 32'd1);
        model_reset();
        bus.valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_word(8'hFF, 0);
        check("t4_data", 32'(bus.data_o), 32'hFF);
        idle(2);

`ifdef SHIFT_DESERIALIZER_DOUBLE_BUFFER_EN
        // Continuous stream: one word per TO cycles.
        bus.ready_i = 1'b1;
        xfer_cyc.delete();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        idle(2);
        if (xfer_cyc.size() == 2)
            check("t5_gap", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd8);
        else
            check("t5_count", 32'(xfer_cyc.size()), 32'd2);

        // Two words pile up behind a stalled consumer.
        bus.ready_i = 1'b0;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        bus.valid_i = 1'b0;
        check("t6_first", 32'(bus.data_o), 32'hA5);
        check("t6_stall", 32'(bus.ready_o), 32'd0);
        bus.ready_i = 1'b1;
        tick(a);
        check("t6_second", 32'(bus.data_o), 32'h3C);
        check("t6_ready", 32'(bus.ready_o), 32'd1);
        tick(a);
        check("t6_empty", 32'(bus.valid_o), 32'd0);
`endif

        // Random traffic; the sender holds a bit until it is taken.
        a = 1'b1;
        bus.valid_i = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!(bus.valid_i && !a)) begin
                bus.valid_i = ($urandom_range(0, 3) != 0);
                bus.data_i  = 1'($urandom_range(0, 1));
            end
            bus.ready_i = ($urandom_range(0, 2) != 0);
            tick(a);
        end
        bus.ready_i = 1'b1;
        idle(4);
        check("drain_valid", 32'(bus.valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
